demux_route_scheduler: RTL and testbench

- Upstream feeder for the 1-to-4, 2-bit demultiplexer stage. Owns that stage's A and SEL inputs.
- Accepts 2-bit data words, each tagged with a 2-bit destination, through a valid/ready handshake, and buffers them in a small FIFO.
- Issues one word per cycle to the demux, only when the addressed destination reports ready.
- Discards a head word that stays blocked past a timeout, so one stalled destination cannot hang the other three.

---
 rtl/demux_route_scheduler.sv | 175 +++++++++++++++++
 tb/tb_demux_route_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_route_scheduler.sv
// Feeder for the 1-to-4 demux: buffers {dest,data} words, issues one per cycle to a ready
// destination and drops a head word blocked past TIMEOUT. ROUTE_STATS_EN adds issue/drop counters.
module demux_route_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8,
    parameter int TW      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_data,
    input  logic [1:0]                 in_dest,
    input  logic [3:0]                 dst_ready,
    output logic [1:0]                 A,
    output logic [1:0]                 SEL,
    output logic                       a_valid,
    output logic                       drop,
    output logic [1:0]                 drop_dest,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef ROUTE_STATS_EN
    ,
    output logic [31:0]                issue_cnt,
    output logic [7:0]                 drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_nxt;
    logic [TW-1:0]   r_stall;
    logic [TW-1:0]   w_stall_nxt;
    logic [1:0]      r_a;
    logic [1:0]      r_sel;
    logic            r_a_valid;
    logic            r_drop;
    logic [1:0]      r_drop_dest;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_drop;
    logic [3:0]      w_hd;
    logic [1:0]      w_hd_dest;
    logic [1:0]      w_hd_data;
    logic            w_hd_ready;

    assign w_full     = (r_count == FULL_CNT);
    assign w_push     = in_valid && !w_full;
    assign w_hd       = r_mem[r_rd_ptr];
    assign w_hd_dest  = w_hd[3:2];
    assign w_hd_data  = w_hd[1:0];
    assign w_hd_ready = dst_ready[w_hd_dest];
    assign w_pop      = w_issue || w_drop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next state looks at the post-edge occupancy so a word pushed while IDLE issues one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        w_stall_nxt = r_stall;
        case (r_state)
            S_IDLE: begin
                if (w_count_nxt != '0) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (w_hd_ready) begin
                    w_issue     = 1'b1;
                    w_stall_nxt = '0;
                    w_state_nxt = (w_count_nxt != '0) ? S_ARB : S_IDLE;
                end else begin
                    w_stall_nxt = TW'(1);
                    w_state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                if (w_hd_ready) begin
                    w_issue     = 1'b1;
                    w_stall_nxt = '0;
                    w_state_nxt = (w_count_nxt != '0) ? S_ARB : S_IDLE;
                end else if (TIMEOUT != 0 && r_stall == TO_CNT) begin
                    w_drop      = 1'b1;
                    w_stall_nxt = '0;
                    w_state_nxt = (w_count_nxt != '0) ? S_ARB : S_IDLE;
                end else if (r_stall != '1) begin
                    w_stall_nxt = r_stall + TW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_stall     <= '0;
            r_a         <= '0;
            r_sel       <= '0;
            r_a_valid   <= 1'b0;
            r_drop      <= 1'b0;
            r_drop_dest <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_stall     <= w_stall_nxt;
            r_drop      <= w_drop;
            r_drop_dest <= w_drop ? w_hd_dest : 2'd0;
            r_a_valid   <= w_issue;
            r_a         <= w_issue ? w_hd_data : 2'd0;
            if (w_issue) r_sel <= w_hd_dest;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_dest, in_data};
    end

`ifdef ROUTE_STATS_EN
    logic [3:0][7:0] r_issue_cnt;
    logic [7:0]      r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_issue) r_issue_cnt[w_hd_dest] <= r_issue_cnt[w_hd_dest] + 8'd1;
            if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign issue_cnt = r_issue_cnt;
    assign drop_cnt  = r_drop_cnt;
`else
    // Statistics hardware is absent in this build.
`endif

    assign in_ready   = !w_full;
    assign A          = r_a;
    assign SEL        = r_sel;
    assign a_valid    = r_a_valid;
    assign drop       = r_drop;
    assign drop_dest  = r_drop_dest;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_demux_route_scheduler.sv
// Directed bench for demux_route_scheduler: issue order, full FIFO, timeout drop, reset flush.
module tb_demux_route_scheduler;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic [1:0] in_dest;
    logic [3:0] dst_ready;
    logic [1:0] A;
    logic [1:0] SEL;
    logic       a_valid;
    logic       drop;
    logic [1:0] drop_dest;
    logic [2:0] fifo_count;
`ifdef ROUTE_STATS_EN
    logic [31:0] issue_cnt;
    logic [7:0]  drop_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    demux_route_scheduler #(.DEPTH(4), .TIMEOUT(8), .TW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .dst_ready  (dst_ready),
        .A          (A),
        .SEL        (SEL),
        .a_valid    (a_valid),
        .drop       (drop),
        .drop_dest  (drop_dest),
        .fifo_count (fifo_count)
`ifdef ROUTE_STATS_EN
        ,
        .issue_cnt  (issue_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic [1:0] w_dest [5];
    logic [1:0] w_data [5];
    int         idx;
    logic       acc;
    int         ndrop;
    int         npush;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; dst_ready = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_a_valid", a_valid, 0);
        check("rst_A", A, 0);
        check("rst_SEL", SEL, 0);
        check("rst_drop", drop, 0);
        check("rst_drop_dest", drop_dest, 0);
        check("rst_count", fifo_count, 0);

        // single word, latency
        dst_ready = 4'hF;
        in_valid = 1'b1; in_dest = 2'd2; in_data = 2'd3;
        tick();
        in_valid = 1'b0;
        check("t1_count_after_push", fifo_count, 1);
        check("t1_no_bypass", a_valid, 0);
        tick();
        check("t1_a_valid", a_valid, 1);
        check("t1_SEL", SEL, 2);
        check("t1_A", A, 3);
        check("t1_count", fifo_count, 0);
        tick();
        check("t1_idle_a_valid", a_valid, 0);
        check("t1_idle_A", A, 0);
        check("t1_sel_hold", SEL, 2);

        // back-to-back, one issue per cycle in order
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                in_valid = 1'b1; in_dest = 2'(k); in_data = 2'((k + 1) % 4);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k >= 1) begin
                check("t2_a_valid", a_valid, 1);
                check("t2_SEL", SEL, k - 1);
                check("t2_A", A, k % 4);
                check("t2_drop", drop, 0);
            end
        end
        tick();
        check("t2_empty", fifo_count, 0);
        check("t2_idle", a_valid, 0);

        // fill with blocked head (dest 1), timeout drop, held 5th word
        w_dest[0] = 2'd1; w_data[0] = 2'd1;
        w_dest[1] = 2'd0; w_data[1] = 2'd2;
        w_dest[2] = 2'd3; w_data[2] = 2'd3;
        w_dest[3] = 2'd2; w_data[3] = 2'd0;
        w_dest[4] = 2'd0; w_data[4] = 2'd1;
        dst_ready = 4'hD;
        idx = 0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                in_dest = w_dest[idx]; in_data = w_data[idx];
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            if (cyc == 3) begin
                check("t3_full_ready", in_ready, 0);
                check("t3_full_count", fifo_count, 4);
            end
            if (cyc == 4) begin
                check("t3_full_hold_count", fifo_count, 4);
                check("t3_fifth_held", idx, 4);
            end
            if (cyc <= 8) begin
                check("t3_hol_no_issue", a_valid, 0);
                check("t3_no_early_drop", drop, 0);
            end
            if (cyc == 9) begin
                check("t4_drop", drop, 1);
                check("t4_drop_dest", drop_dest, 1);
                check("t4_drop_not_valid", a_valid, 0);
                check("t4_count_after_drop", fifo_count, 3);
            end
            if (cyc == 10) begin
                check("t4_next_valid", a_valid, 1);
                check("t4_next_SEL", SEL, 0);
                check("t4_next_A", A, 2);
                check("t4_drop_one_cycle", drop, 0);
                check("t4_pushpop_count", fifo_count, 3);
                check("t4_fifth_taken", idx, 5);
            end
        end
        in_valid = 1'b0;
        tick();
        check("t3_w2_SEL", SEL, 3);
        check("t3_w2_A", A, 3);
        tick();
        check("t3_w3_SEL", SEL, 2);
        check("t3_w3_A", A, 0);
        tick();
        check("t3_w4_valid", a_valid, 1);
        check("t3_w4_SEL", SEL, 0);
        check("t3_w4_A", A, 1);
        check("t3_drained", fifo_count, 0);
        tick();

        // blocked for a few cycles then released; then reset with 3 buffered
        dst_ready = 4'h0;
        in_valid = 1'b1; in_dest = 2'd2; in_data = 2'd1; tick();
        in_dest = 2'd1; in_data = 2'd2; tick();
        in_dest = 2'd3; in_data = 2'd3; tick();
        in_valid = 1'b0;
        tick();
        check("t5_blocked_valid", a_valid, 0);
        check("t5_blocked_count", fifo_count, 3);
        check("t5_blocked_drop", drop, 0);
        dst_ready = 4'h4;
        tick();
        check("t5_release_valid", a_valid, 1);
        check("t5_release_SEL", SEL, 2);
        check("t5_release_A", A, 1);
        check("t5_release_drop", drop, 0);
        check("t5_release_count", fifo_count, 2);
        in_valid = 1'b1; in_dest = 2'd0; in_data = 2'd0;
        tick();
        in_valid = 1'b0;
        check("t5_three_buffered", fifo_count, 3);
        check("t5_hol_blocked", a_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_valid", a_valid, 0);
        check("t6_rst_drop", drop, 0);
        check("t6_rst_SEL", SEL, 0);
        check("t6_rst_ready", in_ready, 1);
        dst_ready = 4'h0;
        ndrop = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (drop || a_valid) ndrop++;
        end
        check("t6_flush_silent", ndrop, 0);
        check("t6_flush_count", fifo_count, 0);

`ifdef ROUTE_STATS_EN
        check("st_rst_issue", issue_cnt, 0);
        check("st_rst_drop", drop_cnt, 0);
        dst_ready = 4'hF; in_dest = 2'd1; in_data = 2'd0;
        npush = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid = (npush < 255);
            acc = in_valid && in_ready;
            tick();
            if (acc) npush++;
        end
        check("st_x_255", issue_cnt[15:8], 255);
        in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); tick();
        check("st_x_wrap", issue_cnt[15:8], 0);
        check("st_others", {issue_cnt[31:16], issue_cnt[7:0]}, 0);
        dst_ready = 4'h0; in_dest = 2'd0; in_valid = 1'b1;
        ndrop = 0;
        for (int c = 0; c < 4000 && ndrop < 300; c++) begin
            tick();
            if (drop) ndrop++;
        end
        in_valid = 1'b0;
        check("st_drop_bound", ndrop, 300);
        check("st_drop_sat", drop_cnt, 255);
        check("st_w_unissued", issue_cnt[7:0], 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("st_clear_issue", issue_cnt, 0);
        check("st_clear_drop", drop_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
